// File: rtl/operand_fetch.sv
// Operand-fetch stage: register file read with write-back bypass,
// RV32I immediate generation and a single valid/ready output slot.
module operand_fetch #(
    parameter int DATA_W        = 32,
    parameter bit STALL_REFRESH = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [31:0]       pc_in,
    input  logic [6:0]        opcode,
    input  logic [4:0]        rd,
    input  logic [4:0]        rs1,
    input  logic [4:0]        rs2,
    input  logic [2:0]        funct3,
    input  logic [6:0]        funct7,
    input  logic              wb_en,
    input  logic [4:0]        wb_rd,
    input  logic [DATA_W-1:0] wb_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       out_pc,
    output logic [6:0]        out_opcode,
    output logic [4:0]        out_rd,
    output logic [2:0]        out_funct3,
    output logic [6:0]        out_funct7,
    output logic [4:0]        out_rs1_idx,
    output logic [4:0]        out_rs2_idx,
    output logic [DATA_W-1:0] out_rs1_data,
    output logic [DATA_W-1:0] out_rs2_data,
    output logic [DATA_W-1:0] out_imm
);

    typedef struct packed {
        logic [31:0]       pc;
        logic [6:0]        opcode;
        logic [4:0]        rd;
        logic [2:0]        funct3;
        logic [6:0]        funct7;
        logic [4:0]        rs1_idx;
        logic [4:0]        rs2_idx;
        logic [DATA_W-1:0] rs1_data;
        logic [DATA_W-1:0] rs2_data;
        logic [DATA_W-1:0] imm;
    } slot_t;

    logic [DATA_W-1:0] rf_q [32];
    logic [DATA_W-1:0] rf_d [32];
    slot_t             slot_q, slot_d;
    logic              valid_q, valid_d;

    logic              wr_en;
    logic              accept;
    logic [31:7]       instr;
    logic [DATA_W-1:0] imm;
    logic [DATA_W-1:0] rs1_val;
    logic [DATA_W-1:0] rs2_val;
    logic              is_i, is_s, is_b, is_u, is_j;

    assign wr_en    = wb_en && (wb_rd != 5'd0);
    assign in_ready = !valid_q || out_ready;
    assign accept   = in_valid && in_ready;
    // Opcode bits never feed an immediate, so only [31:7] is rebuilt.
    assign instr    = {funct7, rs2, rs1, funct3, rd};

    assign is_i = (opcode == 7'b0010011) || (opcode == 7'b0000011)
               || (opcode == 7'b1100111);
    assign is_s = (opcode == 7'b0100011);
    assign is_b = (opcode == 7'b1100011);
    assign is_u = (opcode == 7'b0110111) || (opcode == 7'b0010111);
    assign is_j = (opcode == 7'b1101111);

    always_comb begin
        imm = '0;
        unique case (1'b1)
            is_i: imm = {{20{instr[31]}}, instr[31:20]};
            is_s: imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
            is_b: imm = {{19{instr[31]}}, instr[31], instr[7],
                         instr[30:25], instr[11:8], 1'b0};
            is_u: imm = {instr[31:12], 12'b0};
            is_j: imm = {{11{instr[31]}}, instr[31], instr[19:12],
                         instr[20], instr[30:21], 1'b0};
            default: imm = '0;
        endcase
    end

    always_comb begin
        rs1_val = rf_q[rs1];
        rs2_val = rf_q[rs2];
        if (wr_en && (wb_rd == rs1)) rs1_val = wb_data;
        if (wr_en && (wb_rd == rs2)) rs2_val = wb_data;
        if (rs1 == 5'd0) rs1_val = '0;
        if (rs2 == 5'd0) rs2_val = '0;
    end

    always_comb begin
        rf_d = rf_q;
        if (wr_en) rf_d[wb_rd] = wb_data;
    end

    always_comb begin
        valid_d = valid_q;
        slot_d  = slot_q;
        if (accept) begin
            valid_d         = 1'b1;
            slot_d.pc       = pc_in;
            slot_d.opcode   = opcode;
            slot_d.rd       = rd;
            slot_d.funct3   = funct3;
            slot_d.funct7   = funct7;
            slot_d.rs1_idx  = rs1;
            slot_d.rs2_idx  = rs2;
            slot_d.rs1_data = rs1_val;
            slot_d.rs2_data = rs2_val;
            slot_d.imm      = imm;
        end else if (out_ready) begin
            valid_d = 1'b0;
        end else if (STALL_REFRESH && valid_q && wr_en) begin
            // Held operands track write-backs that land while stalled.
            if (wb_rd == slot_q.rs1_idx) slot_d.rs1_data = wb_data;
            if (wb_rd == slot_q.rs2_idx) slot_d.rs2_data = wb_data;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < 32; i++) rf_q[i] <= '0;
            valid_q <= 1'b0;
            slot_q  <= '0;
        end else begin
            rf_q    <= rf_d;
            valid_q <= valid_d;
            slot_q  <= slot_d;
        end
    end

    assign out_valid    = valid_q;
    assign out_pc       = slot_q.pc;
    assign out_opcode   = slot_q.opcode;
    assign out_rd       = slot_q.rd;
    assign out_funct3   = slot_q.funct3;
    assign out_funct7   = slot_q.funct7;
    assign out_rs1_idx  = slot_q.rs1_idx;
    assign out_rs2_idx  = slot_q.rs2_idx;
    assign out_rs1_data = slot_q.rs1_data;
    assign out_rs2_data = slot_q.rs2_data;
    assign out_imm      = slot_q.imm;

endmodule
